// File: rtl/forwarding_unit_pkg.sv
// -----------------------------------------------------------------------------
// forwarding_unit_pkg
// Shared types and constants for the forwarding scoreboard:
//   - default parameter values for forwarding_scoreboard
//   - stage_entry_t : one tracked producer (valid, rd, we, ready_at)
//   - forward_sel encoding: 0 = no forwarding, k+1 = forward from stage k
// -----------------------------------------------------------------------------
package forwarding_unit_pkg;

  localparam int DEF_NUM_READ_PORTS = 3;
  localparam int DEF_NUM_STAGES     = 3;
  localparam int DEF_CNT_WIDTH      = 16;

  localparam int REG_W = 5;

  // ready_at is stored at a fixed width so the struct does not depend on the
  // NUM_STAGES override; 4 bits covers pipelines of up to 16 tracked stages.
  localparam int STAGE_IDX_W = 4;

  typedef struct packed {
    logic                   valid;
    logic [REG_W-1:0]       rd;
    logic                   we;
    logic [STAGE_IDX_W-1:0] ready_at;
  } stage_entry_t;

  localparam stage_entry_t ENTRY_INVALID = '0;

  localparam int FWD_NONE = 0;

  // Operand-mux select value that picks the output of stage k.
  function automatic int fwd_from_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Per-read-port matching and priority selection. Finds the youngest tracked
// stage that writes the requested source register; forwards from it if its
// result already exists there, otherwise flags a RAW hazard.
// Ports:
//   i_entries  tracked stage entries, index 0 = youngest (Execute)
//   i_rs       source register of this port
//   i_rs_used  this port actually reads i_rs
//   o_sel      0 = register file, k+1 = forward from stage k
//   o_hazard   youngest producer has not produced its result yet
// -----------------------------------------------------------------------------
module forward_select
  import forwarding_unit_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int SEL_W      = $clog2(DEF_NUM_STAGES + 1)
) (
  input  stage_entry_t [NUM_STAGES-1:0] i_entries,
  input  logic [REG_W-1:0]              i_rs,
  input  logic                          i_rs_used,
  output logic [SEL_W-1:0]              o_sel,
  output logic                          o_hazard
);

  logic [NUM_STAGES-1:0] w_match;

  // x0 is hard-wired zero, so a producer targeting it never forwards or stalls.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_match[k] = i_entries[k].valid && i_entries[k].we && i_rs_used &&
                   (i_entries[k].rd == i_rs) && (i_entries[k].rd != '0);
    end
  end

  // Walk from oldest to youngest so the youngest match is the last writer.
  always_comb begin
    // NOTE: outputs get defaults before any branch, so no path leaves them
    // unassigned and no latch is inferred.
    o_sel    = SEL_W'(FWD_NONE);
    o_hazard = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        if (int'(i_entries[k].ready_at) <= k) begin
          o_sel    = SEL_W'(fwd_from_stage(k));
          o_hazard = 1'b0;
        end else begin
          o_sel    = SEL_W'(FWD_NONE);
          o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// forwarding_scoreboard
// Tracks the producers in the stages after decode, drives the operand
// forwarding selects for every decode read port and stalls decode on a
// read-after-write hazard that forwarding cannot cover (e.g. load-use).
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   issue_*          instruction in decode (valid, rd, we, ready_at stage)
//   rs, rs_used      decode source registers and their use flags, per port
//   hold             freeze the tracked pipeline and the stall counter
//   flush            kill the issuing instruction
//   forward_sel      per port: 0 = register file, k+1 = forward from stage k
//   stall            decode must hold this cycle; a bubble enters stage 0
//   stall_count      saturating count of RAW stall cycles
// NUM_STAGES is expected to be in 2..16.
// -----------------------------------------------------------------------------
module forwarding_scoreboard
  import forwarding_unit_pkg::*;
#(
  parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                                                  clock,
  input  logic                                                  reset_n,
  input  logic                                                  issue_valid,
  input  logic [REG_W-1:0]                                      issue_rd,
  input  logic                                                  issue_we,
  input  logic [$clog2(NUM_STAGES)-1:0]                         issue_ready_at,
  input  logic [NUM_READ_PORTS-1:0][REG_W-1:0]                  rs,
  input  logic [NUM_READ_PORTS-1:0]                             rs_used,
  input  logic                                                  hold,
  input  logic                                                  flush,
  output logic [NUM_READ_PORTS-1:0][$clog2(NUM_STAGES+1)-1:0]   forward_sel,
  output logic                                                  stall,
  output logic [CNT_WIDTH-1:0]                                  stall_count
);

  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  stage_entry_t [NUM_STAGES-1:0] r_entries;
  logic [CNT_WIDTH-1:0]          r_stall_count;

  logic [NUM_READ_PORTS-1:0]     w_hazard;
  logic                          w_accept;
  stage_entry_t                  w_issue_entry;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    forward_select #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_forward_select (
      .i_entries (r_entries),
      .i_rs      (rs[p]),
      .i_rs_used (rs_used[p]),
      .o_sel     (forward_sel[p]),
      .o_hazard  (w_hazard[p])
    );
  end

  // A flushed instruction never stalls: it is discarded, not waiting on data.
  assign stall    = issue_valid && !flush && (|w_hazard);
  assign w_accept = issue_valid && !flush && !stall;

  assign w_issue_entry = '{valid:    1'b1,
                           rd:       issue_rd,
                           we:       issue_we,
                           ready_at: STAGE_IDX_W'(issue_ready_at)};

  // hold outranks everything: entries and counter keep their values.
  // NOTE: every valid bit is reset asynchronously so in-flight producers
  // vanish the moment reset_n falls, not at the next clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_entries     <= '0;
      r_stall_count <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value, so the shift needs no ordering care.
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_entries[k] <= r_entries[k-1];
      end
      // The oldest entry simply falls off the end of the shift.
      r_entries[0] <= w_accept ? w_issue_entry : ENTRY_INVALID;
      if (stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forwarding_scoreboard
// Directed scenarios for forwarding, load-use stall, priority, hold, flush and
// asynchronous reset, followed by a randomized run against a reference model.
// Two DUT copies share all inputs: CNT_WIDTH = 16 and CNT_WIDTH = 4 (the
// latter exercises stall_count saturation).
// -----------------------------------------------------------------------------
module tb_forwarding_scoreboard;

  localparam int NP = 3;
  localparam int NS = 3;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               issue_valid;
  logic [4:0]         issue_rd;
  logic               issue_we;
  logic [1:0]         issue_ready_at;
  logic [NP-1:0][4:0] rs;
  logic [NP-1:0]      rs_used;
  logic               hold;
  logic               flush;

  logic [NP-1:0][1:0] forward_sel, forward_sel4;
  logic               stall, stall4;
  logic [15:0]        stall_count;
  logic [3:0]         stall_count4;

  int n_checks = 0;
  int n_errors = 0;

  forwarding_scoreboard #(.NUM_READ_PORTS(NP), .NUM_STAGES(NS), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_ready_at(issue_ready_at), .rs(rs), .rs_used(rs_used),
    .hold(hold), .flush(flush), .forward_sel(forward_sel), .stall(stall),
    .stall_count(stall_count)
  );

  forwarding_scoreboard #(.NUM_READ_PORTS(NP), .NUM_STAGES(NS), .CNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_ready_at(issue_ready_at), .rs(rs), .rs_used(rs_used),
    .hold(hold), .flush(flush), .forward_sel(forward_sel4), .stall(stall4),
    .stall_count(stall_count4)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0; issue_ready_at = '0;
    rs = '0; rs_used = '0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic present_issue(input logic [4:0] rd, input logic [1:0] ready_at);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd; issue_ready_at = ready_at;
  endtask

  // Inputs change right after the falling edge; outputs are read #1 later.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle();
    #2 reset_n = 1'b0;
    present_issue(5'd5, 2'd1);
    rs[0] = 5'd5; rs_used = '1;
    #1;
    n_checks++; if (forward_sel !== '0) begin n_errors++; $display("FAIL reset_fwd: forward_sel=%h expected 0", forward_sel); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: stall=%b expected 0", stall); end
    n_checks++; if (stall_count !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: stall_count=%0d expected 0", stall_count); end
    n_checks++; if (stall_count4 !== 4'd0) begin n_errors++; $display("FAIL reset_cnt4: stall_count=%0d expected 0", stall_count4); end
    @(negedge clock);
    reset_n = 1'b1;
    idle();
  endtask

  task automatic test_alu_forward();
    apply_reset();
    present_issue(5'd5, 2'd0);
    tick();
    present_issue(5'd6, 2'd0);
    rs[0] = 5'd5; rs_used = 3'b001;
    #1;
    n_checks++; if (forward_sel[0] !== 2'd1) begin n_errors++; $display("FAIL alu_fwd_ex: forward_sel[0]=%0d expected 1", forward_sel[0]); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL alu_no_stall: stall=%b expected 0", stall); end
    tick();
    issue_valid = 1'b0;
    rs[0] = 5'd5; rs[1] = 5'd6; rs_used = 3'b011;
    #1;
    n_checks++; if (forward_sel[0] !== 2'd2) begin n_errors++; $display("FAIL alu_fwd_mem: forward_sel[0]=%0d expected 2", forward_sel[0]); end
    n_checks++; if (forward_sel[1] !== 2'd1) begin n_errors++; $display("FAIL alu_fwd_ex2: forward_sel[1]=%0d expected 1", forward_sel[1]); end
    tick();
    #1;
    n_checks++; if (forward_sel[0] !== 2'd3) begin n_errors++; $display("FAIL alu_fwd_wb: forward_sel[0]=%0d expected 3", forward_sel[0]); end
    tick();
    #1;
    n_checks++; if (forward_sel[0] !== 2'd0) begin n_errors++; $display("FAIL alu_retired: forward_sel[0]=%0d expected 0", forward_sel[0]); end
    n_checks++; if (forward_sel[1] !== 2'd3) begin n_errors++; $display("FAIL alu_fwd_wb2: forward_sel[1]=%0d expected 3", forward_sel[1]); end
    idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    present_issue(5'd7, 2'd1);
    tick();
    present_issue(5'd8, 2'd0);
    rs[1] = 5'd7; rs_used = 3'b010;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL load_use_stall: stall=%b expected 1", stall); end
    n_checks++; if (forward_sel[1] !== 2'd0) begin n_errors++; $display("FAIL load_use_nofwd: forward_sel[1]=%0d expected 0", forward_sel[1]); end
    tick();
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL load_use_release: stall=%b expected 0", stall); end
    n_checks++; if (forward_sel[1] !== 2'd2) begin n_errors++; $display("FAIL load_use_fwd: forward_sel[1]=%0d expected 2", forward_sel[1]); end
    n_checks++; if (stall_count !== 16'd1) begin n_errors++; $display("FAIL load_use_cnt: stall_count=%0d expected 1", stall_count); end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++; if (forward_sel[1] !== 2'd3) begin n_errors++; $display("FAIL load_use_wb: forward_sel[1]=%0d expected 3", forward_sel[1]); end
    n_checks++; if (stall_count !== 16'd1) begin n_errors++; $display("FAIL load_use_once: stall_count=%0d expected 1", stall_count); end
    idle();
  endtask

  task automatic test_youngest_wins();
    apply_reset();
    present_issue(5'd3, 2'd0); tick();
    present_issue(5'd9, 2'd0); tick();
    present_issue(5'd3, 2'd0); tick();
    issue_valid = 1'b0;
    rs[0] = 5'd9; rs[2] = 5'd3; rs_used = 3'b101;
    #1;
    n_checks++; if (forward_sel[2] !== 2'd1) begin n_errors++; $display("FAIL youngest_wins: forward_sel[2]=%0d expected 1", forward_sel[2]); end
    n_checks++; if (forward_sel[0] !== 2'd2) begin n_errors++; $display("FAIL middle_stage: forward_sel[0]=%0d expected 2", forward_sel[0]); end
    rs_used = 3'b001;
    #1;
    n_checks++; if (forward_sel[2] !== 2'd0) begin n_errors++; $display("FAIL unused_port: forward_sel[2]=%0d expected 0", forward_sel[2]); end
    rs_used = '0;
    present_issue(5'd0, 2'd1);
    tick();
    present_issue(5'd4, 2'd1); issue_we = 1'b0;
    rs = '0; rs_used = '1;
    #1;
    n_checks++; if (forward_sel !== '0) begin n_errors++; $display("FAIL rd0_fwd: forward_sel=%h expected 0", forward_sel); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rd0_stall: stall=%b expected 0", stall); end
    tick();
    present_issue(5'd12, 2'd0);
    rs[0] = 5'd4; rs_used = 3'b001;
    #1;
    n_checks++; if (forward_sel[0] !== 2'd0 || stall !== 1'b0) begin n_errors++; $display("FAIL no_we: forward_sel[0]=%0d stall=%b expected 0 0", forward_sel[0], stall); end
    idle();
  endtask

  task automatic test_hold();
    apply_reset();
    present_issue(5'd7, 2'd1);
    tick();
    present_issue(5'd8, 2'd0);
    rs[1] = 5'd7; rs_used = 3'b010; hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1 || forward_sel[1] !== 2'd0) begin n_errors++; $display("FAIL hold_frozen[%0d]: stall=%b forward_sel[1]=%0d expected 1 0", i, stall, forward_sel[1]); end
      n_checks++; if (stall_count !== 16'd0) begin n_errors++; $display("FAIL hold_cnt[%0d]: stall_count=%0d expected 0", i, stall_count); end
      tick();
    end
    hold = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hold_resume_stall: stall=%b expected 1", stall); end
    tick();
    #1;
    n_checks++; if (forward_sel[1] !== 2'd2 || stall !== 1'b0) begin n_errors++; $display("FAIL hold_resume_fwd: forward_sel[1]=%0d stall=%b expected 2 0", forward_sel[1], stall); end
    n_checks++; if (stall_count !== 16'd1) begin n_errors++; $display("FAIL hold_resume_cnt: stall_count=%0d expected 1", stall_count); end
    idle();
  endtask

  task automatic test_flush();
    apply_reset();
    present_issue(5'd7, 2'd1);
    tick();
    present_issue(5'd8, 2'd0); flush = 1'b1;
    rs[1] = 5'd7; rs_used = 3'b010;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_no_stall: stall=%b expected 0", stall); end
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    rs[0] = 5'd8; rs[1] = 5'd7; rs_used = 3'b011;
    #1;
    n_checks++; if (forward_sel[0] !== 2'd0) begin n_errors++; $display("FAIL flush_killed: forward_sel[0]=%0d expected 0", forward_sel[0]); end
    n_checks++; if (forward_sel[1] !== 2'd2) begin n_errors++; $display("FAIL flush_advance: forward_sel[1]=%0d expected 2", forward_sel[1]); end
    n_checks++; if (stall_count !== 16'd0) begin n_errors++; $display("FAIL flush_cnt: stall_count=%0d expected 0", stall_count); end
    idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    present_issue(5'd7, 2'd1);
    tick();
    present_issue(5'd8, 2'd1);
    rs[1] = 5'd7; rs_used = 3'b010;
    tick();
    #1;
    n_checks++; if (forward_sel[1] !== 2'd2 || stall_count !== 16'd1) begin n_errors++; $display("FAIL areset_pre: forward_sel[1]=%0d stall_count=%0d expected 2 1", forward_sel[1], stall_count); end
    tick();
    present_issue(5'd9, 2'd0);
    rs[0] = 5'd8; rs_used = 3'b001;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL areset_pre_stall: stall=%b expected 1", stall); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (forward_sel !== '0 || forward_sel4 !== '0) begin n_errors++; $display("FAIL areset_fwd: forward_sel=%h/%h expected 0", forward_sel, forward_sel4); end
    n_checks++; if (stall !== 1'b0 || stall4 !== 1'b0) begin n_errors++; $display("FAIL areset_stall: stall=%b/%b expected 0", stall, stall4); end
    n_checks++; if (stall_count !== 16'd0 || stall_count4 !== 4'd0) begin n_errors++; $display("FAIL areset_cnt: stall_count=%0d/%0d expected 0", stall_count, stall_count4); end
    @(negedge clock);
    reset_n = 1'b1;
    idle();
  endtask

  // Reference model: independent per-cycle scan with an unbounded stall count,
  // expected outputs queued when stimulus is applied and compared on readout.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       we;
    int       ready_at;
  } m_entry_t;

  typedef struct {
    logic [NP-1:0][1:0] sel;
    logic               stall;
    logic [15:0]        cnt;
    logic [3:0]         cnt4;
  } exp_t;

  exp_t     exp_q[$];
  m_entry_t m_pipe[NS];
  int       m_cnt;

  task automatic test_random();
    exp_t e;
    bit   any_haz;
    apply_reset();
    m_cnt = 0;
    for (int k = 0; k < NS; k++) m_pipe[k] = '{valid: 1'b0, rd: 5'd0, we: 1'b0, ready_at: 0};
    for (int cyc = 0; cyc < 10000; cyc++) begin
      issue_valid    = ($urandom_range(0, 9) < 7);
      issue_rd       = 5'($urandom_range(0, 7));
      issue_we       = ($urandom_range(0, 9) < 8);
      issue_ready_at = 2'($urandom_range(0, 2));
      for (int p = 0; p < NP; p++) rs[p] = 5'($urandom_range(0, 7));
      rs_used = 3'($urandom_range(0, 7));
      hold    = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 9) == 0);

      any_haz = 1'b0;
      for (int p = 0; p < NP; p++) begin
        bit found;
        found    = 1'b0;
        e.sel[p] = 2'd0;
        for (int k = 0; k < NS; k++) begin
          if (!found && m_pipe[k].valid && m_pipe[k].we && rs_used[p] &&
              m_pipe[k].rd != 5'd0 && m_pipe[k].rd == rs[p]) begin
            found = 1'b1;
            if (m_pipe[k].ready_at <= k) e.sel[p] = 2'(k + 1);
            else any_haz = 1'b1;
          end
        end
      end
      e.stall = issue_valid && !flush && any_haz;
      e.cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      e.cnt4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
      exp_q.push_back(e);

      #1;
      e = exp_q.pop_front();
      n_checks++; if (forward_sel !== e.sel) begin n_errors++; $display("FAIL rand_fwd cyc %0d: forward_sel=%h expected %h", cyc, forward_sel, e.sel); end
      n_checks++; if (forward_sel4 !== e.sel) begin n_errors++; $display("FAIL rand_fwd4 cyc %0d: forward_sel=%h expected %h", cyc, forward_sel4, e.sel); end
      n_checks++; if (stall !== e.stall) begin n_errors++; $display("FAIL rand_stall cyc %0d: stall=%b expected %b", cyc, stall, e.stall); end
      n_checks++; if (stall4 !== e.stall) begin n_errors++; $display("FAIL rand_stall4 cyc %0d: stall=%b expected %b", cyc, stall4, e.stall); end
      n_checks++; if (stall_count !== e.cnt) begin n_errors++; $display("FAIL rand_cnt cyc %0d: stall_count=%0d expected %0d", cyc, stall_count, e.cnt); end
      n_checks++; if (stall_count4 !== e.cnt4) begin n_errors++; $display("FAIL rand_cnt4 cyc %0d: stall_count=%0d expected %0d", cyc, stall_count4, e.cnt4); end

      if (!hold) begin
        if (e.stall) m_cnt++;
        for (int k = NS - 1; k >= 1; k--) m_pipe[k] = m_pipe[k-1];
        if (issue_valid && !flush && !e.stall)
          m_pipe[0] = '{valid: 1'b1, rd: issue_rd, we: issue_we, ready_at: int'(issue_ready_at)};
        else
          m_pipe[0] = '{valid: 1'b0, rd: 5'd0, we: 1'b0, ready_at: 0};
      end
      tick();
    end
    idle();
    #1;
    if (m_cnt >= 15) begin
      n_checks++; if (stall_count4 !== 4'hF) begin n_errors++; $display("FAIL sat_final: stall_count=%0d expected 15", stall_count4); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest_wins();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
